// File: rtl/round_robin_mux_arbiter_pkg.sv
// Shared sizes and state encoding for the round-robin mux arbiter.
package round_robin_mux_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 2;
    localparam int BEAT_W  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/round_robin_mux_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: first requester after last_owner_i, wrapping.
module rr_priority_pick
    import round_robin_mux_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ADDR_W-1:0]  last_owner_i,
    output logic               found_o,
    output logic [ADDR_W-1:0]  winner_o
);

    logic [ADDR_W-1:0] candidate;

    // k = NUM_REQ wraps back to last_owner_i itself, so it has lowest priority.
    always_comb begin
        found_o   = 1'b0;
        winner_o  = last_owner_i;
        candidate = last_owner_i;
        for (int k = 1; k <= NUM_REQ; k++) begin
            candidate = last_owner_i + ADDR_W'(k);
            if (!found_o && req_i[candidate]) begin
                found_o  = 1'b1;
                winner_o = candidate;
            end
        end
    end

endmodule

// File: rtl/round_robin_mux_arbiter.sv
// Four-way round-robin arbiter that owns a 4:1 mux select for bursts of up
// to MAX_BEATS beats, with a one-cycle arbitration gap between grants.
module round_robin_mux_arbiter
    import round_robin_mux_arbiter_pkg::*;
#(
    parameter int unsigned MAX_BEATS = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] last,
    input  logic               out_ready,
    output logic [NUM_REQ-1:0] gnt,
    output logic               addr0,
    output logic               addr1,
    output logic               out_valid,
    output logic               busy
);

    localparam logic [BEAT_W-1:0] MaxBeatsW = BEAT_W'(MAX_BEATS);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] owner_q, owner_d;
    logic [ADDR_W-1:0] lastOwner_q, lastOwner_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              armed_q;

    logic              pickFound;
    logic [ADDR_W-1:0] pickWinner;
    logic              ownerReq;
    logic              xfer;
    logic [BEAT_W-1:0] beatInc;

    rr_priority_pick u_pick (
        .req_i        (req),
        .last_owner_i (lastOwner_q),
        .found_o      (pickFound),
        .winner_o     (pickWinner)
    );

    // armed_q holds off arbitration for the first edge after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            lastOwner_q <= ADDR_W'(NUM_REQ - 1);
            beat_q      <= '0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lastOwner_q <= lastOwner_d;
            beat_q      <= beat_d;
            armed_q     <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lastOwner_d = lastOwner_q;
        beat_d      = beat_q;
        ownerReq    = req[owner_q];
        xfer        = (state_q == HOLD) && ownerReq && out_ready;
        beatInc     = beat_q + BEAT_W'(1);

        case (state_q)
            IDLE: begin
                if (armed_q && pickFound) begin
                    state_d = HOLD;
                    owner_d = pickWinner;
                    beat_d  = '0;
                end
            end
            HOLD: begin
                if (!ownerReq) begin
                    state_d     = IDLE;
                    lastOwner_d = owner_q;
                end else if (xfer) begin
                    beat_d = beatInc;
                    if (last[owner_q] || (beatInc == MaxBeatsW)) begin
                        state_d     = IDLE;
                        lastOwner_d = owner_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // owner_q keeps its value through IDLE, so the mux select stays put.
    always_comb begin
        gnt       = (state_q == HOLD) ? (NUM_REQ'(1) << owner_q) : '0;
        busy      = (state_q == HOLD);
        out_valid = (state_q == HOLD) && ownerReq;
        addr0     = owner_q[0];
        addr1     = owner_q[1];
    end

endmodule

// File: doc/round_robin_mux_arbiter.md
ROUND_ROBIN_MUX_ARBITER -- requirements
Module: round_robin_mux_arbiter

Interface
REQ-001 Parameter MAX_BEATS, default 4, maximum beats per grant; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  4  request per requester; bit i held high while requester i has data.
REQ-005 last  input  4  bit i marks requester i's current beat as its final beat.
REQ-006 out_ready  input  1  downstream accepts the muxed beat this cycle.
REQ-007 gnt  output  4  one-hot grant; at most one bit high.
REQ-008 addr0  output  1  mux select LSB (owner index bit 0).
REQ-009 addr1  output  1  mux select MSB (owner index bit 1).
REQ-010 out_valid  output  1  muxed beat is valid.
REQ-011 busy  output  1  high while a grant is held.

Function
REQ-012 Two states SHALL exist: IDLE and HOLD.
- IDLE: gnt=0, out_valid=0, busy=0; addr1:addr0 hold the previous owner index.
- HOLD: gnt=one-hot(owner), busy=1, addr1:addr0=owner, out_valid=req[owner].
REQ-013 IDLE -> HOLD when any req bit high; owner = first requester with req high searching from (last_owner+1) mod 4 upward, wrapping; grant visible the cycle after req is sampled (1-cycle latency).
REQ-014 A beat SHALL transfer on any HOLD cycle with out_valid && out_ready; beat counter increments by 1 per transfer, cleared on entry to HOLD.
REQ-015 HOLD -> IDLE when any of: transfer with last[owner]=1; transfer making beat count equal MAX_BEATS; req[owner]=0 (abandon, no transfer counted).
REQ-016 On HOLD -> IDLE, last_owner SHALL update to owner; IDLE always lasts exactly one cycle when other requests are pending (one-cycle arbitration gap).
REQ-017 Requests arriving or dropping for non-owners during HOLD SHALL NOT affect gnt, addr, or beat count.
REQ-018 Simultaneous requests SHALL be resolved solely by REQ-013 rotation; no requester waits more than 3 grants.
REQ-019 last[] and out_ready SHALL be ignored in IDLE; last[i] for i != owner ignored in HOLD.
REQ-020 Beat counter SHALL be 4 bits, saturating never required since release occurs at MAX_BEATS.
REQ-021 All outputs SHALL be driven from registers or owner-state decode only; no combinational path from req/last/out_ready to gnt/addr.

Reset
REQ-022 On reset_n low, asynchronously: state=IDLE, gnt=0, addr0=0, addr1=0, out_valid=0, busy=0, beat count=0, last_owner=3 (so requester 0 has first priority).
REQ-023 Reset asserted mid-HOLD SHALL abort the grant immediately; no beat counted for that cycle.
REQ-024 After reset_n deasserts, first grant SHALL appear no earlier than the second rising edge.

Structure
REQ-025 Shared package SHALL hold NUM_REQ=4, ADDR_W=2, BEAT_W=4, and the IDLE/HOLD state enumeration.
REQ-026 Round-robin selection SHALL live in combinational sub-module rr_priority_pick (inputs req, last_owner; outputs found, winner index).
REQ-027 addr1:addr0 SHALL be directly connectable to the select inputs of the team's 4:1 multiplexer.

Verification
REQ-028 Reset then req=0001, last asserted on beat 2, out_ready=1 -> gnt=0001 at cycle 1, addr=00, two transfers, return to IDLE, last_owner=0.
REQ-029 req=1111 held, last=1111, out_ready=1 -> grant order 0,1,2,3,0 with one IDLE cycle between grants; addr follows 00,01,10,11,00.
REQ-030 req=0100, last=0, MAX_BEATS=4, out_ready=1 -> exactly 4 transfers then release; re-granted to 2 after one IDLE cycle.
REQ-031 Owner 1 in HOLD, out_ready=0 for 5 cycles, req[3] rises -> gnt stays 0010, beat count 0, out_valid=1 throughout.
REQ-032 Owner 2 drops req mid-burst after 1 beat -> next cycle IDLE, out_valid=0; subsequent grant goes to 3 if requesting.
REQ-033 reset_n pulsed low during HOLD of owner 3 -> gnt=0000, addr=00 asynchronously; next grant with req=1111 goes to 0.
